// File: rtl/mandelbrot_pkg.sv
// Shared Q-format constants and scheduler FSM encoding for the mandelbrot pixel pipeline.
package mandelbrot_pkg;

    localparam int FP_W_DEF = 32;
    localparam int FRAC_DEF = 24;

    localparam logic [FP_W_DEF-1:0] FP_ONE  = 32'h0100_0000;
    localparam logic [FP_W_DEF-1:0] FP_FOUR = 32'h0400_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT,
        ST_FIN
    } state_t;

endpackage

// File: rtl/mandelbrot_coord_gen.sv
// Raster x/y counters and incremental c_re/c_im accumulators; load and advance act on the next edge.
// No backpressure of its own: advance is only asserted by the scheduler on an accepted beat.
module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int FP_W  = FP_W_DEF,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            advance,
    input  logic [FP_W-1:0] re_min,
    input  logic [FP_W-1:0] im_max,
    input  logic [FP_W-1:0] step,
    output logic [X_W-1:0]  x,
    output logic [Y_W-1:0]  y,
    output logic [FP_W-1:0] c_re,
    output logic [FP_W-1:0] c_im,
    output logic            is_last
);

    logic [FP_W-1:0] re_min_q;
    logic [FP_W-1:0] step_q;
    logic            row_end;
    logic            col_end;

    assign row_end = (x == X_W'(H_RES - 1));
    assign col_end = (y == Y_W'(V_RES - 1));
    assign is_last = row_end && col_end;

    // Accumulators wrap modulo 2^FP_W; the view controller keeps the range legal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            c_re     <= '0;
            c_im     <= '0;
            re_min_q <= '0;
            step_q   <= '0;
        end else if (load) begin
            x        <= '0;
            y        <= '0;
            c_re     <= re_min;
            c_im     <= im_max;
            re_min_q <= re_min;
            step_q   <= step;
        end else if (advance && !is_last) begin
            if (!row_end) begin
                x    <= x + X_W'(1);
                c_re <= c_re + step_q;
            end else begin
                x    <= '0;
                y    <= y + Y_W'(1);
                c_re <= re_min_q;
                c_im <= c_im - step_q;
            end
        end
    end

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Walks the raster, starts one core per pixel and streams (x,y,iter) beats; core_start 1 cycle after acceptance,
// pix_valid 1 cycle after core_done; a stalled beat holds its payload and blocks the next core_start.
module mandelbrot_pixel_scheduler
    import mandelbrot_pkg::*;
#(
    parameter int FP_W  = FP_W_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_start,
    input  logic [FP_W-1:0] re_min,
    input  logic [FP_W-1:0] im_max,
    input  logic [FP_W-1:0] step,
    input  logic [7:0]      max_iter,
    output logic            core_start,
    output logic [FP_W-1:0] core_c_re,
    output logic [FP_W-1:0] core_c_im,
    output logic [7:0]      core_max_iter,
    input  logic            core_busy,
    input  logic            core_done,
    input  logic [7:0]      core_iter,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic [X_W-1:0]  pix_x,
    output logic [Y_W-1:0]  pix_y,
    output logic [7:0]      pix_iter,
    output logic            pix_last,
    output logic            frame_busy,
    output logic            frame_done
);

    if (FRAC < 0 || FRAC >= FP_W || X_W < $clog2(H_RES) || Y_W < $clog2(V_RES)
        || X_W < 1 || Y_W < 1) begin : g_param_check
        $error("mandelbrot_pixel_scheduler: illegal parameter combination");
    end

    state_t state;
    state_t state_nxt;
    logic   load;
    logic   advance;
    logic   is_last;

    mandelbrot_coord_gen #(
        .FP_W  (FP_W),
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_coord_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .advance (advance),
        .re_min  (re_min),
        .im_max  (im_max),
        .step    (step),
        .x       (pix_x),
        .y       (pix_y),
        .c_re    (core_c_re),
        .c_im    (core_c_im),
        .is_last (is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    load      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!core_busy) begin
                    core_start = 1'b1;
                    state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (pix_ready) begin
                    advance   = 1'b1;
                    state_nxt = is_last ? ST_FIN : ST_ISSUE;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_max_iter <= '0;
            pix_iter      <= '0;
        end else begin
            if (load) begin
                core_max_iter <= max_iter;
            end
            // core_done outside WAIT is a stray pulse and must not disturb a held beat.
            if (state == ST_WAIT && core_done) begin
                pix_iter <= core_iter;
            end
        end
    end

    assign pix_valid  = (state == ST_OUT);
    assign pix_last   = pix_valid && is_last;
    assign frame_busy = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_OUT);
    assign frame_done = (state == ST_FIN);

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Scoreboard bench for the pixel scheduler: 4x2 raster, stub core of latency 3 returning its start count.
module tb_mandelbrot_pixel_scheduler;
    import mandelbrot_pkg::*;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] re_min = '0;
    logic [31:0] im_max = '0;
    logic [31:0] step = '0;
    logic [7:0]  max_iter = '0;
    logic        core_start;
    logic [31:0] core_c_re;
    logic [31:0] core_c_im;
    logic [7:0]  core_max_iter;
    logic        core_busy;
    logic        core_done;
    logic [7:0]  core_iter;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic [7:0]  pix_iter;
    logic        pix_last;
    logic        frame_busy;
    logic        frame_done;

    logic force_busy = 1'b0;
    logic stray_done = 1'b0;
    logic bp_mode = 1'b0;

    int   cnt;
    int   k;
    logic stub_done;
    logic [7:0] stub_iter;

    int checks = 0;
    int errors = 0;
    int beats = 0;

    typedef struct {
        int          x;
        int          y;
        int          iter;
        int          last;
        logic [31:0] cre;
        logic [31:0] cim;
        logic [7:0]  mi;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mandelbrot_pixel_scheduler #(
        .FP_W(32), .FRAC(24), .H_RES(4), .V_RES(2), .X_W(2), .Y_W(1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .re_min        (re_min),
        .im_max        (im_max),
        .step          (step),
        .max_iter      (max_iter),
        .core_start    (core_start),
        .core_c_re     (core_c_re),
        .core_c_im     (core_c_im),
        .core_max_iter (core_max_iter),
        .core_busy     (core_busy),
        .core_done     (core_done),
        .core_iter     (core_iter),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_iter      (pix_iter),
        .pix_last      (pix_last),
        .frame_busy    (frame_busy),
        .frame_done    (frame_done)
    );

    // Stub core: done L cycles after start, iter = number of starts so far in this frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 0;
            k         <= 0;
            stub_done <= 1'b0;
            stub_iter <= '0;
        end else begin
            stub_done <= (cnt == 1);
            if (core_start) begin
                cnt       <= L;
                k         <= k + 1;
                stub_iter <= k[7:0];
            end else begin
                if (cnt != 0) cnt <= cnt - 1;
                if (!frame_busy) k <= 0;
            end
        end
    end

    assign core_busy = (cnt != 0) || force_busy;
    assign core_done = stub_done || stray_done;
    assign core_iter = stub_iter;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, ".core_start"}, 32'(core_start), 0);
        chk({pfx, ".core_c_re"}, core_c_re, 0);
        chk({pfx, ".core_c_im"}, core_c_im, 0);
        chk({pfx, ".core_max_iter"}, 32'(core_max_iter), 0);
        chk({pfx, ".pix_valid"}, 32'(pix_valid), 0);
        chk({pfx, ".pix_xy"}, 32'({pix_y, pix_x}), 0);
        chk({pfx, ".pix_iter"}, 32'(pix_iter), 0);
        chk({pfx, ".pix_last"}, 32'(pix_last), 0);
        chk({pfx, ".frame_busy"}, 32'(frame_busy), 0);
        chk({pfx, ".frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic pulse_start(input logic [31:0] re, input logic [31:0] im,
                               input logic [31:0] st, input logic [7:0] mi);
        @(posedge clk); #1;
        re_min = re; im_max = im; step = st; max_iter = mi;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] re, input logic [31:0] im,
                               input logic [31:0] st, input logic [7:0] mi);
        exp_t e;
        for (int yy = 0; yy < 2; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                e.x    = xx;
                e.y    = yy;
                e.iter = xx + 4 * yy;
                e.last = (xx == 3 && yy == 1) ? 1 : 0;
                e.cre  = re + 32'(xx) * st;
                e.cim  = im - 32'(yy) * st;
                e.mi   = mi;
                exp_q.push_back(e);
            end
        end
        pulse_start(re, im, st, mi);
    endtask

    task automatic wait_frame(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        chk({name, ".frame_done_seen"}, 32'(frame_done), 1);
        chk({name, ".beats_outstanding"}, 32'(exp_q.size()), 0);
    endtask

    // Downstream: always ready, or in bp_mode ready only after 5 low cycles of each beat.
    initial begin
        int hold;
        hold = 0;
        forever begin
            @(posedge clk); #1;
            if (!bp_mode) begin
                pix_ready = 1'b1;
            end else if (!pix_valid) begin
                pix_ready = 1'b0;
                hold = 0;
            end else if (hold < 5) begin
                pix_ready = 1'b0;
                hold++;
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks hold stability and frame_done timing.
    initial begin
        exp_t e;
        logic held;
        logic exp_done;
        logic [31:0] snap;
        held = 1'b0;
        exp_done = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                exp_done = 1'b0;
                continue;
            end
            if (exp_done || frame_done) begin
                chk("frame_done_timing", 32'(frame_done), 32'(exp_done));
                if (exp_done) chk("frame_busy_at_done", 32'(frame_busy), 0);
            end
            exp_done = 1'b0;
            if (core_start) chk("core_start_during_beat", 32'(pix_valid), 0);
            if (held) begin
                chk("hold_valid", 32'(pix_valid), 1);
                chk("hold_payload", {20'(0), pix_iter, 1'(pix_last), pix_y, pix_x}, snap);
                held = 1'b0;
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(pix_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    beats++;
                    chk("pix_x", 32'(pix_x), e.x);
                    chk("pix_y", 32'(pix_y), e.y);
                    chk("pix_iter", 32'(pix_iter), e.iter);
                    chk("pix_last", 32'(pix_last), e.last);
                    chk("core_c_re", core_c_re, e.cre);
                    chk("core_c_im", core_c_im, e.cim);
                    chk("core_max_iter", 32'(core_max_iter), 32'(e.mi));
                    if (e.last != 0) exp_done = 1'b1;
                end
            end else if (pix_valid) begin
                snap = {20'(0), pix_iter, 1'(pix_last), pix_y, pix_x};
                held = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Basic frame, view -2..1 x 1..0, always ready.
        start_frame(32'hFE00_0000, FP_ONE, FP_ONE, 8'd20);
        wait_frame("t1");

        // Backpressure: 5 stalled cycles per beat.
        bp_mode = 1'b1;
        start_frame(32'hFE00_0000, FP_ONE, FP_ONE, 8'd30);
        wait_frame("t3");
        bp_mode = 1'b0;

        // frame_start mid-frame with new params is ignored; params apply to the next frame.
        start_frame(32'hFE00_0000, FP_ONE, FP_ONE, 8'd20);
        b0 = beats;
        for (int i = 0; i < 500 && beats < b0 + 3; i++) @(negedge clk);
        pulse_start(32'hFF00_0000, FP_FOUR, FP_ONE, 8'd99);
        wait_frame("t4a");
        start_frame(32'hFF00_0000, FP_ONE, FP_ONE, 8'd99);
        wait_frame("t4b");

        // core_busy held in ISSUE delays start; stray core_done during OUT is ignored.
        bp_mode = 1'b1;
        start_frame(32'hFE00_0000, FP_ONE, FP_ONE, 8'd7);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (pix_valid) break;
        end
        @(posedge clk); #1;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!pix_valid) break;
            @(posedge clk); #1;
        end
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5.start_held_off", 32'(core_start), 0);
        end
        @(posedge clk); #1;
        force_busy = 1'b0;
        @(negedge clk);
        chk("t5.start_after_busy", 32'(core_start), 1);
        @(negedge clk);
        chk("t5.start_single_pulse", 32'(core_start), 0);
        wait_frame("t5");
        bp_mode = 1'b0;

        // Reset while pixel 3 is in the core, then a fresh frame from (0,0).
        start_frame(32'hFE00_0000, FP_ONE, FP_ONE, 8'd20);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (k == 3) break;
        end
        chk("t6.in_wait_pixel3", 32'(k), 3);
        rst_n = 1'b0;
        #1;
        check_zero("t6.mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_frame(32'hFE00_0000, FP_ONE, FP_ONE, 8'd20);
        wait_frame("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
